rsa_result_tx: RTL and testbench



---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_result_tx_if.sv | 26 ++
 rtl/rsa_result_tx_fifo.sv | 57 +++++
 rtl/rsa_result_tx.sv | 150 +++++++++++++++
 tb/tb_rsa_result_tx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA result output stage: frame constants,
// FSM state encoding and a frame-length helper.
package rsa_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SEND    = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_t;

  // Bytes on the wire for one N-bit result: sync + data bytes + checksum.
  function automatic int frame_len(input int n);
    return n / 8 + 2;
  endfunction

endpackage

// File: rtl/rsa_result_tx_if.sv
// Result-capture and UART byte handshake bundle between mon_exp, the
// output stage and the UART transmitter.
interface rsa_result_tx_if #(
  parameter int N = 16
);

  logic         rx_valid;
  logic [N-1:0] rx_bytes;
  logic         rx_ready;
  logic         is_transmitting;
  logic [7:0]   tx_byte;
  logic         tx_valid;

  // Environment side: produces results, models the UART.
  modport master (
    output rx_valid, rx_bytes, is_transmitting,
    input  rx_ready, tx_byte, tx_valid
  );

  // Output stage side.
  modport slave (
    input  rx_valid, rx_bytes, is_transmitting,
    output rx_ready, tx_byte, tx_valid
  );

endinterface

// File: rtl/rsa_result_tx_fifo.sv
// Small synchronous FIFO holding whole result words. A push and a pop in
// the same cycle on a full FIFO is accepted: the head is read out before
// its slot is overwritten. DEPTH must be a power of two, at least 2.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == (AW + 1)'(0));
  assign full      = (count_r == (AW + 1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem[rd_ptr_r];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rsa_result_tx.sv
// RSA result output stage: buffers each finished result and streams it to
// the UART as SYNC, data bytes MSB first, then the XOR of the data bytes.
// One byte per is_transmitting low->high->low cycle of the transmitter.
module rsa_result_tx
  import rsa_pkg::*;
#(
  parameter int         N     = 16,
  parameter int         DEPTH = 2,
  parameter logic [7:0] SYNC  = SYNC_BYTE
) (
  input  logic           clk,
  input  logic           rst,
  rsa_result_tx_if.slave bus,
  output logic           busy,
  output logic           overflow
);

  localparam int            FLEN     = frame_len(N);
  localparam int            IW       = $clog2(FLEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FLEN - 1);

  state_t        state_r;
  state_t        state_nx;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_inc_s;
  logic [N-1:0]  shreg_r;
  logic [7:0]    chk_r;
  logic [7:0]    tx_byte_r;
  logic [7:0]    next_byte_s;
  logic          overflow_r;
  logic          tx_valid_s;
  logic          pop_s;
  logic          is_data_s;
  logic          full_s;
  logic          empty_s;
  logic [N-1:0]  head_s;

  result_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rx_valid),
    .pop   (pop_s),
    .wdata (bus.rx_bytes),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Index 0 is SYNC and the last index is the checksum; the rest are data.
  assign is_data_s   = (idx_r != IW'(0)) && (idx_r != LAST_IDX);
  assign idx_inc_s   = idx_r + IW'(1);
  // The shift register and checksum are already updated for the byte just
  // sent, so the following byte is either the new top byte or the checksum.
  assign next_byte_s = (idx_inc_s == LAST_IDX) ? chk_r : shreg_r[N-1 -: 8];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  // Next-state, FIFO pop and transmit strobe.
  always_comb begin
    state_nx   = state_r;
    pop_s      = 1'b0;
    tx_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_nx = LOAD;
        else          state_nx = IDLE;
      end
      LOAD: begin
        pop_s    = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        if (!bus.is_transmitting) begin
          tx_valid_s = 1'b1;
          state_nx   = WAIT_HI;
        end else begin
          state_nx   = SEND;
        end
      end
      WAIT_HI: begin
        if (bus.is_transmitting) state_nx = WAIT_LO;
        else                     state_nx = WAIT_HI;
      end
      WAIT_LO: begin
        if (!bus.is_transmitting) begin
          if (idx_r == LAST_IDX) state_nx = IDLE;
          else                   state_nx = SEND;
        end else begin
          state_nx = WAIT_LO;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame datapath: byte index, shift register, checksum and held tx byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r     <= IW'(0);
      shreg_r   <= N'(0);
      chk_r     <= 8'h00;
      tx_byte_r <= 8'h00;
    end else begin
      case (state_r)
        LOAD: begin
          shreg_r   <= head_s;
          chk_r     <= 8'h00;
          idx_r     <= IW'(0);
          tx_byte_r <= SYNC;
        end
        SEND: begin
          if (tx_valid_s && is_data_s) begin
            shreg_r <= {shreg_r[N-9:0], 8'h00};
            chk_r   <= chk_r ^ shreg_r[N-1 -: 8];
          end
        end
        WAIT_LO: begin
          if (!bus.is_transmitting && (idx_r != LAST_IDX)) begin
            idx_r     <= idx_inc_s;
            tx_byte_r <= next_byte_s;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Sticky drop flag: a result arrived with the FIFO full and no pop.
  always_ff @(posedge clk) begin
    if (rst)                                        overflow_r <= 1'b0;
    else if (bus.rx_valid && full_s && !pop_s)      overflow_r <= 1'b1;
    else                                            overflow_r <= overflow_r;
  end

  assign bus.tx_valid = tx_valid_s;
  assign bus.tx_byte  = tx_byte_r;
  assign bus.rx_ready = !full_s;
  assign busy         = (state_r != IDLE) || !empty_s;
  assign overflow     = overflow_r;

endmodule

// File: tb/tb_rsa_result_tx.sv
// Directed bench for rsa_result_tx: a 16-bit and a 32-bit instance, each
// with a UART model that holds is_transmitting for 10 cycles per byte.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_rsa_result_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy16, ovf16, busy32, ovf32;
  logic hold16 = 1'b0;
  int   cnt16 = 0;
  int   cnt32 = 0;
  int   cyc = 0;
  logic prev16 = 1'b0;
  logic prev32 = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] got16 [$];
  logic [7:0] got32 [$];
  int         tcyc16 [$];

  rsa_result_tx_if #(.N(16)) bus16 ();
  rsa_result_tx_if #(.N(32)) bus32 ();

  rsa_result_tx #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .busy(busy16), .overflow(ovf16)
  );
  rsa_result_tx #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32), .busy(busy32), .overflow(ovf32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART models: busy for 10 cycles after each accepted byte.
  always @(posedge clk) begin
    if (bus16.tx_valid)   cnt16 <= 10;
    else if (cnt16 != 0)  cnt16 <= cnt16 - 1;
    if (bus32.tx_valid)   cnt32 <= 10;
    else if (cnt32 != 0)  cnt32 <= cnt32 - 1;
  end
  assign bus16.is_transmitting = hold16 | (cnt16 != 0);
  assign bus32.is_transmitting = (cnt32 != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte monitors plus the tx_valid pacing rules, every cycle.
  always @(negedge clk) begin
    chk("tx16_pacing", 32'(bus16.tx_valid & (bus16.is_transmitting | prev16)), 32'd0);
    chk("tx32_pacing", 32'(bus32.tx_valid & (bus32.is_transmitting | prev32)), 32'd0);
    if (bus16.tx_valid) begin
      got16.push_back(bus16.tx_byte);
      tcyc16.push_back(cyc);
    end
    if (bus32.tx_valid) got32.push_back(bus32.tx_byte);
    prev16 <= bus16.tx_valid;
    prev32 <= bus32.tx_valid;
  end

  task automatic chk_frame(input string tag, input logic [7:0] q [$],
                           input logic [127:0] exp, input int len);
    logic [7:0] b;
    chk({tag, "_len"}, 32'(q.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      b = (i < q.size()) ? q[i] : 8'hxx;
      chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[8*(len-1-i) +: 8]));
    end
  endtask

  task automatic drive16(input logic [15:0] w);
    @(posedge clk); #1;
    bus16.rx_valid = 1'b1;
    bus16.rx_bytes = w;
  endtask

  task automatic release16();
    @(posedge clk); #1;
    bus16.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int n = 0;
    while (n < budget && ((sel == 16) ? (busy16 || bus16.is_transmitting)
                                      : (busy32 || bus32.is_transmitting))) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_bytes16(input int nb, input int budget);
    int n = 0;
    while (got16.size() < nb && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("bytes_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic clear16();
    got16.delete();
    tcyc16.delete();
  endtask

  initial begin
    int pc;
    int rc;
    bus16.rx_valid = 1'b0; bus16.rx_bytes = 16'h0000;
    bus32.rx_valid = 1'b0; bus32.rx_bytes = 32'h0000_0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(bus16.tx_valid), 32'd0);
    chk("rst_tx_byte",  32'(bus16.tx_byte),  32'h00);
    chk("rst_overflow", 32'(ovf16),          32'd0);
    chk("rst_busy",     32'(busy16),         32'd0);
    chk("rst_rx_ready", 32'(bus16.rx_ready), 32'd1);
    chk("rst_rx_ready32", 32'(bus32.rx_ready), 32'd1);
    @(posedge clk); #1; rst = 1'b0;

    // Test 1: single frame and the 3-cycle latency
    drive16(16'h1234);
    pc = cyc;
    release16();
    wait_idle(16, 400);
    chk("t1_latency", (tcyc16.size() > 0) ? 32'(tcyc16[0] - pc) : 32'hFFFF_FFFF, 32'd3);
    chk_frame("t1", got16, 128'hA5123426, 4);
    chk("t1_overflow", 32'(ovf16), 32'd0);
    clear16();

    // Test 2: two results on consecutive cycles, back-to-back frames
    drive16(16'hBEEF);
    drive16(16'h0001);
    release16();
    wait_idle(16, 800);
    chk("t2_byte_gap", (tcyc16.size() > 1) ? 32'(tcyc16[1] - tcyc16[0]) : 32'hFFFF_FFFF, 32'd12);
    chk("t2_frame_gap", (tcyc16.size() > 4) ? 32'(tcyc16[4] - tcyc16[3]) : 32'hFFFF_FFFF, 32'd14);
    chk_frame("t2", got16, 128'hA5BEEF51_A5000101, 8);
    chk("t2_overflow", 32'(ovf16), 32'd0);
    clear16();

    // Test 3: frame in flight, FIFO fills with two more, a third is dropped
    drive16(16'h1111);
    release16();
    wait_bytes16(1, 100);
    drive16(16'h2222); release16();
    drive16(16'h3333); release16();
    drive16(16'h4444); release16();
    @(negedge clk);
    chk("t3_overflow_set", 32'(ovf16), 32'd1);
    chk("t3_rx_ready_full", 32'(bus16.rx_ready), 32'd0);
    wait_idle(16, 1200);
    chk_frame("t3", got16, 128'hA5111100_A5222200_A5333300, 12);
    chk("t3_overflow_sticky", 32'(ovf16), 32'd1);
    clear16();

    // Test 4: UART held busy for 500 cycles before the frame
    @(posedge clk); #1; hold16 = 1'b1;
    drive16(16'hC3A5);
    release16();
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("t4_no_tx_while_held", 32'(got16.size()), 32'd0);
    chk("t4_busy_while_held", 32'(busy16), 32'd1);
    @(posedge clk); #1; hold16 = 1'b0;
    rc = cyc;
    wait_idle(16, 400);
    chk("t4_release_latency", (tcyc16.size() > 0) ? 32'(tcyc16[0] - rc) : 32'hFFFF_FFFF, 32'd0);
    chk_frame("t4", got16, 128'hA5C3A566, 4);
    clear16();

    // Test 5: reset after the second byte abandons the frame
    drive16(16'h5678);
    release16();
    wait_bytes16(2, 200);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t5_tx_valid", 32'(bus16.tx_valid), 32'd0);
    chk("t5_busy",     32'(busy16),         32'd0);
    chk("t5_rx_ready", 32'(bus16.rx_ready), 32'd1);
    chk("t5_overflow_cleared", 32'(ovf16),  32'd0);
    repeat (60) @(negedge clk);
    chk_frame("t5_partial", got16, 128'hA556, 2);
    clear16();
    drive16(16'h9A3C);
    release16();
    wait_idle(16, 400);
    chk_frame("t5_after", got16, 128'hA59A3CA6, 4);
    clear16();

    // Test 6: 32-bit result
    @(posedge clk); #1;
    bus32.rx_valid = 1'b1;
    bus32.rx_bytes = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus32.rx_valid = 1'b0;
    wait_idle(32, 600);
    chk_frame("t6", got32, 128'hA5DEADBEEF22, 6);
    chk("t6_overflow", 32'(ovf32), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
